// File: rtl/msg_buffer_pkg.sv
// msg_buffer_pkg: character codes and FSM encodings shared by the message buffer
package msg_buffer_pkg;
  localparam logic [7:0] CHAR_CR        = 8'h0D;
  localparam logic [7:0] CHAR_BS        = 8'h08;
  localparam logic [7:0] CHAR_ESC       = 8'h1B;
  localparam logic [7:0] CHAR_SPACE     = 8'h20;
  localparam logic [7:0] CHAR_PRINT_MIN = 8'h20;
  localparam logic [7:0] CHAR_PRINT_MAX = 8'h7E;
  typedef enum logic {IDLE, CLEAR} main_state_e;
  typedef enum logic [1:0] {E_IDLE, E_START, E_DONE} echo_state_e;
  function automatic logic is_printable(input logic [7:0] c);
    return c >= CHAR_PRINT_MIN && c <= CHAR_PRINT_MAX;
  endfunction
endpackage

// File: rtl/msg_buffer_echo_fifo.sv
// echo_fifo: small synchronous FIFO holding bytes waiting to be echoed
module echo_fifo #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         clk_in,
  input  logic         nrst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(D);
  logic [W-1:0] mem_q [D];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign empty = cnt_q == '0;
  assign full = cnt_q == (AW+1)'(D);
  assign head = mem_q[rp_q];
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // pointer and occupancy bookkeeping; a simultaneous push and pop leaves the count unchanged
  always_comb begin
    wp_d = do_push ? wp_q + AW'(1) : wp_q;
    rp_d = do_pop ? rp_q + AW'(1) : rp_q;
    cnt_d = (do_push && !do_pop) ? cnt_q + (AW+1)'(1) : (!do_push && do_pop) ? cnt_q - (AW+1)'(1) : cnt_q;
  end
  // pointer/count registers
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  // storage needs no reset; empty gates every read
  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wp_q] <= din;
  end
endmodule

// File: rtl/msg_buffer.sv
// msg_buffer: 16-character line buffer with editing keys, clear sequence and UART echo
module msg_buffer
  import msg_buffer_pkg::*;
#(
  parameter bit         ECHO_EN   = 1'b1,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic       clk_in,
  input  logic       nrst,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic [3:0] rd_pos,
  output logic [7:0] rd_char,
  output logic [3:0] wr_ptr,
  output logic       busy,
  output logic       rx_drop,
  output logic       tx_transmit,
  output logic [7:0] tx_byte,
  input  logic       tx_busy,
  output logic       echo_ovf
);
  main_state_e state_q, state_d;
  echo_state_e e_state_q, e_state_d;
  logic [7:0] buf_q [16];
  logic [3:0] wr_ptr_q, wr_ptr_d, idx_q, idx_d, wa;
  logic [7:0] wd, rd_char_q, tx_byte_q, tx_byte_d, head;
  logic we, acc, push, pop, full, empty;
  logic rx_drop_q, rx_drop_d, tx_transmit_q, tx_transmit_d, echo_ovf_q, echo_ovf_d;
  assign rd_char = rd_char_q;
  assign wr_ptr = wr_ptr_q;
  assign busy = state_q == CLEAR;
  assign rx_drop = rx_drop_q;
  assign tx_transmit = tx_transmit_q;
  assign tx_byte = tx_byte_q;
  assign echo_ovf = echo_ovf_q;
  assign push = ECHO_EN && acc;
  // byte decode in IDLE, sequential fill sweep in CLEAR
  always_comb begin
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    idx_d = idx_q;
    we = 1'b0;
    wa = wr_ptr_q;
    wd = rx_byte;
    acc = 1'b0;
    rx_drop_d = 1'b0;
    if (state_q == CLEAR) begin
      we = 1'b1;
      wa = idx_q;
      wd = FILL_CHAR;
      idx_d = idx_q + 4'd1;
      state_d = idx_q == 4'd15 ? IDLE : CLEAR;
      rx_drop_d = rx_valid;
    end else if (rx_valid) begin
      if (is_printable(rx_byte)) begin
        we = 1'b1;
        wr_ptr_d = wr_ptr_q + 4'd1;
        acc = 1'b1;
      end else if (rx_byte == CHAR_CR) begin
        wr_ptr_d = 4'd0;
        acc = 1'b1;
      end else if (rx_byte == CHAR_BS) begin
        acc = 1'b1;
        if (wr_ptr_q != 4'd0) begin
          we = 1'b1;
          wa = wr_ptr_q - 4'd1;
          wd = FILL_CHAR;
          wr_ptr_d = wr_ptr_q - 4'd1;
        end
      end else if (rx_byte == CHAR_ESC) begin
        wr_ptr_d = 4'd0;
        idx_d = 4'd0;
        state_d = CLEAR;
        acc = 1'b1;
      end
    end
  end
  // echo handshake: pop and request, wait for the UART to start, then wait for it to finish
  always_comb begin
    e_state_d = e_state_q;
    pop = 1'b0;
    tx_transmit_d = 1'b0;
    tx_byte_d = tx_byte_q;
    case (e_state_q)
      E_IDLE: if (!empty && !tx_busy) begin
        pop = 1'b1;
        tx_transmit_d = 1'b1;
        tx_byte_d = head;
        e_state_d = E_START;
      end
      E_START: if (tx_busy) e_state_d = E_DONE;
      E_DONE: if (!tx_busy) e_state_d = E_IDLE;
      default: e_state_d = E_IDLE;
    endcase
    echo_ovf_d = push && full && !pop;
  end
  // control and output registers
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      e_state_q <= E_IDLE;
      wr_ptr_q <= 4'd0;
      idx_q <= 4'd0;
      rd_char_q <= 8'd0;
      tx_byte_q <= 8'd0;
      tx_transmit_q <= 1'b0;
      rx_drop_q <= 1'b0;
      echo_ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      e_state_q <= e_state_d;
      wr_ptr_q <= wr_ptr_d;
      idx_q <= idx_d;
      rd_char_q <= buf_q[rd_pos];
      tx_byte_q <= tx_byte_d;
      tx_transmit_q <= tx_transmit_d;
      rx_drop_q <= rx_drop_d;
      echo_ovf_q <= echo_ovf_d;
    end
  end
  // character store, forced to the fill value whenever reset is asserted
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < 16; i++) buf_q[i] <= FILL_CHAR;
    end else if (we) begin
      buf_q[wa] <= wd;
    end
  end
  echo_fifo #(.W(8), .D(4)) u_fifo (
    .clk_in(clk_in),
    .nrst(nrst),
    .push(push),
    .pop(pop),
    .din(rx_byte),
    .full(full),
    .empty(empty),
    .head(head)
  );
endmodule
